// File: rtl/atmospheric_light_recip_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : atmospheric_light_recip_sequencer
// Purpose : Shares one 1/A LUT across R, G, B and publishes the set by valid/ready.
// Rev     : 1.0
// ============================================================================
module atmospheric_light_recip_sequencer #(
    parameter int          AW        = 8,
    parameter int          RW        = 10,
    parameter int unsigned A_MIN     = 1,
    parameter int unsigned RST_RECIP = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_end,
    input  logic [AW-1:0] A_R,
    input  logic [AW-1:0] A_G,
    input  logic [AW-1:0] A_B,
    output logic [AW-1:0] lut_addr,
    input  logic [RW-1:0] lut_data,
    output logic [RW-1:0] inv_A_R,
    output logic [RW-1:0] inv_A_G,
    output logic [RW-1:0] inv_A_B,
    output logic          recip_valid,
    input  logic          recip_ready,
    output logic          busy,
    output logic          overrun
);

    localparam logic [AW-1:0] c_a_min     = AW'(A_MIN);
    localparam logic [RW-1:0] c_rst_recip = RW'(RST_RECIP);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LK_R = 3'd1,
        S_LK_G = 3'd2,
        S_LK_B = 3'd3,
        S_WAIT = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          w_publish;
    logic [AW-1:0] r_work_r, r_work_g, r_work_b;
    logic [AW-1:0] r_shadow_r, r_shadow_g, r_shadow_b;
    logic [RW-1:0] r_stage_r, r_stage_g, r_stage_b;
    logic          r_pending;
    logic [AW-1:0] w_clamp_r, w_clamp_g, w_clamp_b;

    function automatic logic [AW-1:0] clamp_a(input logic [AW-1:0] a);
        return (a < c_a_min) ? c_a_min : a;
    endfunction

    assign w_clamp_r = clamp_a(A_R);
    assign w_clamp_g = clamp_a(A_G);
    assign w_clamp_b = clamp_a(A_B);
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        lut_addr     = '0;
        w_publish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frame_end) begin
                    w_next_state = S_LK_R;
                end
            end
            S_LK_R: begin
                lut_addr     = r_work_r;
                w_next_state = S_LK_G;
            end
            S_LK_G: begin
                lut_addr     = r_work_g;
                w_next_state = S_LK_B;
            end
            S_LK_B: begin
                lut_addr = r_work_b;
                if (!recip_valid || recip_ready) begin
                    w_publish = 1'b1;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (recip_ready) begin
                    w_publish = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        // A frame_end coinciding with publish is chained straight into LK_R.
        if (w_publish) begin
            w_next_state = (r_pending || frame_end) ? S_LK_R : S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work_r    <= '0;
            r_work_g    <= '0;
            r_work_b    <= '0;
            r_shadow_r  <= '0;
            r_shadow_g  <= '0;
            r_shadow_b  <= '0;
            r_stage_r   <= c_rst_recip;
            r_stage_g   <= c_rst_recip;
            r_stage_b   <= c_rst_recip;
            inv_A_R     <= c_rst_recip;
            inv_A_G     <= c_rst_recip;
            inv_A_B     <= c_rst_recip;
            recip_valid <= 1'b0;
            r_pending   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            case (r_state)
                S_LK_R:  r_stage_r <= lut_data;
                S_LK_G:  r_stage_g <= lut_data;
                S_LK_B:  r_stage_b <= lut_data;
                default: ;
            endcase

            if (w_publish) begin
                inv_A_R     <= r_stage_r;
                inv_A_G     <= r_stage_g;
                inv_A_B     <= (r_state == S_LK_B) ? lut_data : r_stage_b;
                recip_valid <= 1'b1;
            end else if (recip_ready) begin
                recip_valid <= 1'b0;
            end

            if (r_state == S_IDLE) begin
                if (frame_end) begin
                    r_work_r <= w_clamp_r;
                    r_work_g <= w_clamp_g;
                    r_work_b <= w_clamp_b;
                end
            end else if (frame_end) begin
                if (r_pending) begin
                    overrun <= 1'b1;
                end
                // On a publish edge the newest request overwrites the shadow and is consumed at once.
                if (w_publish) begin
                    r_work_r  <= w_clamp_r;
                    r_work_g  <= w_clamp_g;
                    r_work_b  <= w_clamp_b;
                    r_pending <= 1'b0;
                end else begin
                    r_shadow_r <= w_clamp_r;
                    r_shadow_g <= w_clamp_g;
                    r_shadow_b <= w_clamp_b;
                    r_pending  <= 1'b1;
                end
            end else if (w_publish && r_pending) begin
                r_work_r  <= r_shadow_r;
                r_work_g  <= r_shadow_g;
                r_work_b  <= r_shadow_b;
                r_pending <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
